// File: rtl/cla_seq_arbiter_pkg.sv
// Shared definitions for the sequential carry-lookahead arbiter.
//   SLICE_W  width of the shared lookahead slice (bits added per cycle)
//   state_t  controller state encoding
//   cnt_w    width helper for the chunk counter (never below 1 bit)
package cla_seq_arbiter_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead adder slice, purely combinational.
//   a, b   4-bit operands
//   cin    carry into bit 0
//   sum    a + b + cin, low 4 bits
//   c3     carry into bit 3 (used for signed overflow on the top chunk)
//   cout   carry out of bit 3
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c3,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign c3   = c[3];
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_arbiter.sv
// Two-requester round-robin front end to a single 4-bit lookahead slice.
// An accepted add is processed one 4-bit chunk per cycle, LSB first, with the
// carry registered between chunks; the result is offered on a valid/ready port.
//   clk, rst_n                        clock, async active-low reset
//   req0_valid/ready/a/b/cin          requester 0 (valid & ready = accept)
//   req1_valid/ready/a/b/cin          requester 1
//   rsp_valid/ready                   response handshake
//   rsp_id                            requester index of the result
//   rsp_sum, rsp_cout, rsp_ovf        sum mod 2^WIDTH, carry out, signed overflow
//
// state | meaning
// IDLE  | offering ready to one valid requester
// RUN   | adding one chunk per cycle
// DONE  | holding the response until rsp_ready
module cla_seq_arbiter
  import cla_seq_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = cnt_w(NSLICE);
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic [KW-1:0]    k;

  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic [3:0]       s_sum;
  logic             s_c3;
  logic             s_cout;
  logic [WIDTH-1:0] sum_next;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == ST_IDLE) begin
      gnt0 = req0_valid & (~req1_valid | last_grant);
      gnt1 = req1_valid & (~req0_valid | ~last_grant);
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;

  // Operands shift right each chunk so the slice always sees the low nibble;
  // result nibbles enter at the top and reach their place after NSLICE shifts.
  cla4_slice u_slice (
    .a    (a_reg[3:0]),
    .b    (b_reg[3:0]),
    .cin  (carry_reg),
    .sum  (s_sum),
    .c3   (s_c3),
    .cout (s_cout)
  );

  assign sum_next = (sum_reg >> SLICE_W) | (WIDTH'(s_sum) << (WIDTH - SLICE_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      carry_reg  <= 1'b0;
      k          <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_reg      <= gnt1 ? req1_a   : req0_a;
            b_reg      <= gnt1 ? req1_b   : req0_b;
            carry_reg  <= gnt1 ? req1_cin : req0_cin;
            last_grant <= gnt1;
            k          <= '0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_reg     <= a_reg >> SLICE_W;
          b_reg     <= b_reg >> SLICE_W;
          sum_reg   <= sum_next;
          carry_reg <= s_cout;
          if (k == K_LAST) begin
            // Top chunk: c3 is the carry into the MSB, so ovf comes straight from the slice.
            rsp_valid <= 1'b1;
            rsp_id    <= last_grant;
            rsp_sum   <= sum_next;
            rsp_cout  <= s_cout;
            rsp_ovf   <= s_c3 ^ s_cout;
            state     <= ST_DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_arbiter.sv
module tb_cla_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [15:0] rsp_sum;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cla_seq_arbiter #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {cout,sum} = a+b+cin, ovf from operand/result signs.
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] t;
    logic        ovf;
    t   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    ovf = (a[15] == b[15]) && (t[15] != a[15]);
    return {ovf, t};
  endfunction

  // Called just after a posedge that was the accept edge; returns edges until rsp_valid.
  task automatic wait_rsp(input string tag, output int n);
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_add(input string tag, input bit id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec, input logic eo);
    int n;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
    @(negedge clk);
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(tag, n);
    chk({tag, "_lat"}, n, 32'd4);
    chk({tag, "_sum"}, rsp_sum, es);
    chk({tag, "_cout"}, rsp_cout, ec);
    chk({tag, "_ovf"}, rsp_ovf, eo);
    chk({tag, "_id"}, rsp_id, id);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_drop"}, rsp_valid, 32'd0);
  endtask

  initial begin
    int   n;
    int   ng, nr, bad;
    bit   grants[8];
    int   gcyc[8];
    bit   rids[8];
    logic [15:0] rsums[8];
    logic [17:0] m;
    logic [15:0] ra, rb;
    logic        rc;

    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
    rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_flags", {rsp_id, rsp_cout, rsp_ovf}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", {req0_ready, req1_ready}, 0);

    // Directed vectors, hand-computed
    run_add("t1",  1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_add("t2",  1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_add("t3a", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add("t3b", 1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Both requesters valid, consumer always ready: alternate grants every 6 cycles.
    req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 0;
    req1_valid = 1; req1_a = 16'hF000; req1_b = 16'h1000; req1_cin = 1;
    rsp_ready = 1;
    ng = 0; nr = 0; bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) bad++;
      if ((req0_ready || req1_ready) && ng < 8) begin
        grants[ng] = req1_ready; gcyc[ng] = c; ng++;
      end
      if (rsp_valid && nr < 8) begin
        rids[nr] = rsp_id; rsums[nr] = rsp_sum; nr++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    chk("t4_both_ready", bad, 0);
    chk("t4_ngrants", (ng >= 4), 1);
    chk("t4_nrsp", (nr >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_grant%0d", i), grants[i], i % 2);
      chk($sformatf("t4_rid%0d", i), rids[i], i % 2);
      chk($sformatf("t4_rsum%0d", i), rsums[i], (i % 2) ? 16'h0001 : 16'h3333);
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("t4_gap%0d", i), gcyc[i+1] - gcyc[i], 6);
    // Let any in-flight add drain.
    rsp_ready = 1;
    repeat (8) @(posedge clk);
    #1;
    rsp_ready = 0;

    // Back-pressure: response held, no ready offered while DONE.
    req0_valid = 1; req0_a = 16'h0F0F; req0_b = 16'h00F1; req0_cin = 0;
    @(negedge clk);
    chk("t5_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    wait_rsp("t5", n);
    req0_valid = 1; req1_valid = 1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_sum !== 16'h1000 || rsp_id !== 1'b0 || rsp_cout !== 1'b0
          || rsp_ovf !== 1'b0 || req0_ready || req1_ready) bad++;
    end
    chk("t5_hold", bad, 0);
    @(posedge clk); #1;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("t5_xfer", rsp_valid, 0);
    chk("t5_rr", {req0_ready, req1_ready}, 2'b01);
    req0_valid = 0; req1_valid = 0;

    // Reset in the 2nd chunk cycle discards the add.
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 16'hAAAA; req0_b = 16'h5555; req0_cin = 0;
    @(posedge clk); #1;
    req0_valid = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_sum", rsp_sum, 0);
    repeat (6) @(negedge clk);
    chk("t6_no_rsp", rsp_valid, 0);
    rst_n = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 0;
    req1_valid = 1; req1_a = 16'hFFFF; req1_b = 16'hFFFF; req1_cin = 1;
    @(negedge clk);
    chk("t6_tie", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_rsp("t6", n);
    chk("t6_lat", n, 4);
    chk("t6_sum", rsp_sum, 16'h5555);
    chk("t6_id", rsp_id, 0);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;

    // Random vectors against the reference model.
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      m  = ref_add(ra, rb, rc);
      run_add($sformatf("rnd%0d", i), 1'(i), ra, rb, rc, m[15:0], m[16], m[17]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
